alu_result_stage: RTL and testbench

- Registered output stage placed directly downstream of the 32-bit ALU built from chained bit slices.
- Captures the ALU result word, final adder carry-out and operand sign bits, then derives zero/carry/overflow flags.
- Presents the result and flags to the next consumer (register-file writeback or flag register) over a valid/ready handshake.
- A 2-entry skid buffer decouples ALU timing from downstream stalls without dropping or duplicating results.

---
 rtl/alu_result_stage_if.sv | 38 +++
 rtl/alu_result_stage.sv | 128 ++++++++++++
 tb/tb_alu_result_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the downstream
// consumer. The stage sits on the slave modport. The master modport is the
// environment's view: it drives the ALU word and the consumer's ready.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = 32
);
  // Upstream (ALU -> stage)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic [2:0]       in_cmd;

  // Downstream (stage -> consumer)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_cmd;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_result, in_carryout, in_a_msb, in_b_msb, in_cmd,
    output in_ready,
    output out_valid, out_result, out_cmd, out_zero, out_carry, out_overflow,
    input  out_ready
  );

  modport master (
    output in_valid, in_result, in_carryout, in_a_msb, in_b_msb, in_cmd,
    input  in_ready,
    input  out_valid, out_result, out_cmd, out_zero, out_carry, out_overflow,
    output out_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered output stage behind the bit-slice ALU. It captures the result
// word, derives the zero/carry/overflow flags and hands them downstream over
// valid/ready. A one-entry skid register behind the output register lets the
// stage absorb one extra result when the consumer stalls, so in_ready depends
// only on registered state.
module alu_result_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_stage_if.slave    bus,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  // One held result: word, selector and the flags derived at capture time.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       cmd;
    logic             zero;
    logic             carry;
    logic             overflow;
  } entry_t;

  entry_t inEntry;
  entry_t outEntry;
  entry_t skidEntry;
  logic   outValid;
  logic   skidValid;

  cmd_e   inCmd;
  logic   isArith;
  logic   accept;
  logic   consume;
  logic   outLoad;
  logic   cntFull;

  // Flag derivation from the raw ALU outputs. Carry and overflow only mean
  // something for the adder ops; the logic ops and SLT report zero only.
  always_comb begin
    inCmd   = cmd_e'(bus.in_cmd);
    isArith = (inCmd == CMD_ADD) || (inCmd == CMD_SUB);

    inEntry          = '0;
    inEntry.result   = bus.in_result;
    inEntry.cmd      = bus.in_cmd;
    inEntry.zero     = ~|bus.in_result;
    inEntry.carry    = isArith & bus.in_carryout;
    inEntry.overflow = isArith
                     & (bus.in_a_msb == bus.in_b_msb)
                     & (bus.in_result[WIDTH-1] != bus.in_a_msb);
  end

  // Handshake qualifiers. The output register reloads whenever it is empty
  // or its current word leaves this cycle.
  always_comb begin
    accept  = bus.in_valid && !skidValid;
    consume = outValid && bus.out_ready;
    outLoad = !outValid || consume;
    cntFull = &op_count;
  end

  // Output register: the skid entry always drains first to keep FIFO order.
  // in_ready is low while the skid entry is held, so an accept can never
  // coincide with a skid drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      outEntry <= '0;
    end else if (outLoad) begin
      if (skidValid) begin
        outValid <= 1'b1;
        outEntry <= skidEntry;
      end else if (accept) begin
        outValid <= 1'b1;
        outEntry <= inEntry;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

  // Skid register: catches an accepted word only when the output register
  // is occupied and stalled; it empties on the next output reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      skidValid <= 1'b0;
      skidEntry <= '0;
    end else if (accept && !outLoad) begin
      skidValid <= 1'b1;
      skidEntry <= inEntry;
    end else if (outLoad && skidValid) begin
      skidValid <= 1'b0;
    end
  end

  // Completed-handshake counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (consume && !cntFull) begin
      op_count <= op_count + CNT_WIDTH'(1);
    end
  end

  // Drive the bus from registered state only.
  always_comb begin
    bus.in_ready     = !skidValid;
    bus.out_valid    = outValid;
    bus.out_result   = outEntry.result;
    bus.out_cmd      = outEntry.cmd;
    bus.out_zero     = outEntry.zero;
    bus.out_carry    = outEntry.carry;
    bus.out_overflow = outEntry.overflow;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage. Expected entries are queued when the
// stage accepts a word and popped when the consumer takes one. The counter is
// built with a 4-bit width so saturation is reachable quickly.
module tb_alu_result_stage;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [2:0]       cmd;
    logic             zero;
    logic             carry;
    logic             overflow;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic [CNT_WIDTH-1:0] opCount;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .op_count (opCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   testsRun    = 0;
  int   testsFailed = 0;
  exp_t expQ[$];
  int   modelCount  = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] r, input logic [2:0] c,
                                 input logic co, input logic am, input logic bm);
    exp_t e;
    logic arith;
    arith      = (c == 3'd0) || (c == 3'd1);
    e.result   = r;
    e.cmd      = c;
    e.zero     = (r == '0);
    e.carry    = arith ? co : 1'b0;
    e.overflow = arith ? ((am == bm) && (r[WIDTH-1] != am)) : 1'b0;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  logic             prevHeld = 1'b0;
  logic [WIDTH-1:0] snapResult;
  logic [2:0]       snapCmd;
  logic [2:0]       snapFlags;

  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      modelCount = 0;
      prevHeld   = 1'b0;
    end else begin
      checkVal("op_count", 64'(opCount), 64'(modelCount));
      if (prevHeld) begin
        checkVal("hold_result", 64'(bus.out_result), 64'(snapResult));
        checkVal("hold_cmd", 64'(bus.out_cmd), 64'(snapCmd));
        checkVal("hold_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}),
                 64'(snapFlags));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkVal("unexpected_out", 64'(bus.out_result), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkVal("out_result", 64'(bus.out_result), 64'(e.result));
          checkVal("out_cmd", 64'(bus.out_cmd), 64'(e.cmd));
          checkVal("out_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}),
                   64'({e.zero, e.carry, e.overflow}));
        end
        if (modelCount < (1 << CNT_WIDTH) - 1) modelCount++;
      end
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(model(bus.in_result, bus.in_cmd, bus.in_carryout,
                             bus.in_a_msb, bus.in_b_msb));
      prevHeld   = bus.out_valid && !bus.out_ready;
      snapResult = bus.out_result;
      snapCmd    = bus.out_cmd;
      snapFlags  = {bus.out_zero, bus.out_carry, bus.out_overflow};
    end
  end

  // Drive one word; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic sendOp(input logic [2:0] c, input logic [WIDTH-1:0] r,
                        input logic co, input logic am, input logic bm);
    logic accepted;
    accepted        = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_cmd      = c;
    bus.in_result   = r;
    bus.in_carryout = co;
    bus.in_a_msb    = am;
    bus.in_b_msb    = bm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) checkVal("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (expQ.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkVal("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkVal({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkVal({tag, "_op_count"}, 64'(opCount), 64'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_cmd      = '0;
    bus.in_carryout = 1'b0;
    bus.in_a_msb    = 1'b0;
    bus.in_b_msb    = 1'b0;
    bus.out_ready   = 1'b1;
    // Keep in_valid high during reset: it must be ignored.
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_result = 32'h1234_5678;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset        = 1'b0;

    // Reset state
    checkIdle("reset");
    checkVal("reset_result", 64'(bus.out_result), 64'd0);
    checkVal("reset_cmd", 64'(bus.out_cmd), 64'd0);
    checkVal("reset_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}), 64'd0);

    // ADD producing zero with carry and signed overflow
    sendOp(3'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkVal("add_valid", 64'(bus.out_valid), 64'd1);
    checkVal("add_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}), 64'b111);
    @(posedge clk); #1;
    checkVal("add_count", 64'(opCount), 64'd1);

    // SUB overflow, then XOR with the same raw inputs
    sendOp(3'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    checkVal("sub_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}), 64'b001);
    sendOp(3'd2, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    checkVal("xor_flags", 64'({bus.out_zero, bus.out_carry, bus.out_overflow}), 64'b000);
    waitDrain();

    // Stall: two words held, third refused until the consumer resumes
    bus.out_ready = 1'b0;
    sendOp(3'd0, 32'h1, 1'b0, 1'b0, 1'b0);
    sendOp(3'd4, 32'h2, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_cmd    = 3'd7;
    bus.in_result = 32'h3;
    @(negedge clk);
    checkVal("stall_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    checkVal("stall_out_result", 64'(bus.out_result), 64'h1);
    checkVal("stall_in_ready2", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    sendOp(3'd7, 32'h3, 1'b0, 1'b0, 1'b0);
    waitDrain();

    // Reset with both entries full: held words must vanish
    bus.out_ready = 1'b0;
    sendOp(3'd3, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
    sendOp(3'd5, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkIdle("midreset");
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkVal("midreset_quiet", 64'(bus.out_valid), 64'd0);

    // Streaming: one word per cycle, skid never needed
    for (int i = 0; i < 20; i++) begin
      bus.in_valid    = 1'b1;
      bus.in_cmd      = 3'($urandom_range(0, 7));
      bus.in_result   = (i == 5) ? 32'h0 : $urandom;
      bus.in_carryout = 1'($urandom);
      bus.in_a_msb    = 1'($urandom);
      bus.in_b_msb    = 1'($urandom);
      @(negedge clk);
      checkVal("stream_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    waitDrain();
    checkVal("sat_count", 64'(opCount), 64'd15);

    // One more consume at saturation must not wrap
    sendOp(3'd6, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    waitDrain();
    checkVal("sat_hold", 64'(opCount), 64'd15);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
